// File: rtl/npc_pkg.sv
// Shared definitions for the next-PC predictor: counter encodings and the
// address slicing used to index and tag the branch target buffer.
package npc_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  function automatic int log2_ceil(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Word-aligned index: addr[idx_w+1:2]; callers size-cast the result.
  function automatic logic [63:0] addr_index(input logic [63:0] addr, input int idx_w);
    return (addr >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  // Tag: everything above the index bits.
  function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int idx_w);
    return addr >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/npc_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters:
// combinational read port on the fetch PC, one update/allocate write port.
module npc_btb
  import npc_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] rd_addr,
  output logic            rd_taken,
  output logic [XLEN-1:0] rd_target,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_addr,
  input  logic            wr_taken,
  input  logic [XLEN-3:0] wr_target
);

  localparam int IDX_W = log2_ceil(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [ENTRIES-1:0] valid_reg;
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [XLEN-3:0]    target_mem [ENTRIES];
  ctr_e               ctr_mem    [ENTRIES];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             rd_hit, wr_hit, wr_alloc;
  ctr_e             ctr_next;

  assign rd_idx = IDX_W'(addr_index(64'(rd_addr), IDX_W));
  assign rd_tag = TAG_W'(addr_tag(64'(rd_addr), IDX_W));
  assign wr_idx = IDX_W'(addr_index(64'(wr_addr), IDX_W));
  assign wr_tag = TAG_W'(addr_tag(64'(wr_addr), IDX_W));

  assign rd_hit    = valid_reg[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rd_taken  = rd_hit && (ctr_mem[rd_idx] inside {WT, ST});
  assign rd_target = rd_hit ? {target_mem[rd_idx], 2'b00} : '0;

  assign wr_hit   = valid_reg[wr_idx] && (tag_mem[wr_idx] == wr_tag);
  assign wr_alloc = wr_en && !wr_hit && wr_taken;

  always_comb begin
    ctr_next = ctr_mem[wr_idx];
    if (!wr_hit) begin
      ctr_next = WT;
    end else if (wr_taken) begin
      if (ctr_mem[wr_idx] != ST) ctr_next = ctr_e'(ctr_mem[wr_idx] + 2'd1);
    end else begin
      if (ctr_mem[wr_idx] != SNT) ctr_next = ctr_e'(ctr_mem[wr_idx] - 2'd1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
    end else if (wr_alloc) begin
      valid_reg[wr_idx] <= 1'b1;
    end
  end

  // A miss that was not taken leaves the entry alone, so a miss here is always an allocate.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_hit || wr_taken)) begin
      ctr_mem[wr_idx] <= ctr_next;
      if (wr_taken) target_mem[wr_idx] <= wr_target;
      if (!wr_hit)  tag_mem[wr_idx]    <= wr_tag;
    end
  end

endmodule

// File: rtl/npc_predictor.sv
// Fetch PC register with BTB-based prediction, execute-stage mispredict
// detection and redirect, and a saturating misprediction counter.
module npc_predictor
  import npc_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(32'h0000_8000),
  parameter int              CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  output logic [XLEN-1:0]  pc,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  input  logic             ex_valid,
  input  logic             ex_is_ctrl,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic             ex_taken,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  output logic             flush,
  output logic [CNT_W-1:0] mispred_count
);

  logic [XLEN-1:0]  pc_reg, pc_next, redirect_pc;
  logic [CNT_W-1:0] mispred_count_reg;
  logic             mispredict;

  npc_btb #(
    .XLEN    (XLEN),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (pc_reg),
    .rd_taken  (pred_taken),
    .rd_target (pred_target),
    .wr_en     (ex_valid && ex_is_ctrl),
    .wr_addr   (ex_pc),
    .wr_taken  (ex_taken),
    .wr_target (ex_target[XLEN-1:2])
  );

  assign mispredict = ex_valid &&
                      ((ex_taken != ex_pred_taken) ||
                       (ex_taken && (ex_target != ex_pred_target)));
  assign flush = mispredict;

  // JALR targets may carry low bits from reg+imm; fetch always stays word aligned.
  assign redirect_pc = ex_taken ? {ex_target[XLEN-1:2], 2'b00} : ex_pc + XLEN'(4);

  always_comb begin
    pc_next = pc_reg + XLEN'(4);
    if (mispredict) begin
      pc_next = redirect_pc;
    end else if (stall) begin
      pc_next = pc_reg;
    end else if (pred_taken) begin
      pc_next = pred_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispred_count_reg <= '0;
    end else if (mispredict && (mispred_count_reg != '1)) begin
      mispred_count_reg <= mispred_count_reg + CNT_W'(1);
    end
  end

  assign pc            = pc_reg;
  assign mispred_count = mispred_count_reg;

endmodule

// File: tb/tb_npc_predictor.sv
// Scenario-driven bench for npc_predictor: expected values are queued when
// stimulus is applied and popped when the corresponding output is sampled.
module tb_npc_predictor;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic        ex_is_ctrl;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        flush;
  logic [31:0] mispred_count;

  logic [31:0] sb[$];
  logic [31:0] expv;
  int          n_cmp;
  int          n_err;
  int          exp_cnt;
  logic        flush_seen;

  npc_predictor dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .pc             (pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_is_ctrl     (ex_is_ctrl),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .flush          (flush),
    .mispred_count  (mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 1'b0; ex_is_ctrl = 1'b0; ex_pc = '0; ex_taken = 1'b0;
    ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
  endtask

  // One-cycle execute resolve; flush is sampled mid-cycle, pc after the edge.
  task automatic drive_ex(input logic [31:0] p, input logic tk, input logic [31:0] tg,
                          input logic ptk, input logic [31:0] ptg);
    ex_valid = 1'b1; ex_is_ctrl = 1'b1; ex_pc = p; ex_taken = tk;
    ex_target = tg; ex_pred_taken = ptk; ex_pred_target = ptg;
    #1 flush_seen = flush;
    tick();
    clear_ex();
    $display("resolve ex_pc=%h taken=%0d target=%h flush=%0d -> pc=%h", p, tk, tg, flush_seen, pc);
  endtask

  // Redirect fetch to t via a not-taken mispredict at t-4 (an address that never allocates).
  task automatic redirect(input logic [31:0] t);
    drive_ex(t - 32'd4, 1'b0, 32'h0, 1'b1, 32'h0);
    exp_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    sb.push_back(32'h8000); sb.push_back(32'h0); sb.push_back(32'h0);
    sb.push_back(32'h0); sb.push_back(32'h0);
    expv = sb.pop_front(); n_cmp++;
    if (pc !== expv) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc, expv); end
    expv = sb.pop_front(); n_cmp++;
    if ({31'b0, pred_taken} !== expv) begin n_err++; $display("FAIL reset_pred_taken: got %0d want %0d", pred_taken, expv); end
    expv = sb.pop_front(); n_cmp++;
    if (pred_target !== expv) begin n_err++; $display("FAIL reset_pred_target: got %h want %h", pred_target, expv); end
    expv = sb.pop_front(); n_cmp++;
    if ({31'b0, flush} !== expv) begin n_err++; $display("FAIL reset_flush: got %0d want %0d", flush, expv); end
    expv = sb.pop_front(); n_cmp++;
    if (mispred_count !== expv) begin n_err++; $display("FAIL reset_count: got %0d want %0d", mispred_count, expv); end
    rst = 1'b0;
    #1;
    sb.push_back(32'h8000);
    expv = sb.pop_front(); n_cmp++;
    if (pc !== expv) begin n_err++; $display("FAIL seq_pc0: got %h want %h", pc, expv); end
    for (int i = 1; i <= 2; i++) begin
      sb.push_back(32'h8000 + 32'(4 * i));
      tick();
      expv = sb.pop_front(); n_cmp++;
      if (pc !== expv) begin n_err++; $display("FAIL seq_pc%0d: got %h want %h", i, pc, expv); end
    end
  endtask

  task automatic test_alloc();
    sb.push_back(32'h1); sb.push_back(32'h8100);
    drive_ex(32'h8010, 1'b1, 32'h8100, 1'b0, 32'h0);
    exp_cnt++;
    expv = sb.pop_front(); n_cmp++;
    if ({31'b0, flush_seen} !== expv) begin n_err++; $display("FAIL alloc_flush: got %0d want %0d", flush_seen, expv); end
    expv = sb.pop_front(); n_cmp++;
    if (pc !== expv) begin n_err++; $display("FAIL alloc_pc: got %h want %h", pc, expv); end
    sb.push_back(32'(exp_cnt));
    expv = sb.pop_front(); n_cmp++;
    if (mispred_count !== expv) begin n_err++; $display("FAIL alloc_count: got %0d want %0d", mispred_count, expv); end
    redirect(32'h8010);
    sb.push_back(32'h1); sb.push_back(32'h8100); sb.push_back(32'h8100);
    expv = sb.pop_front(); n_cmp++;
    if ({31'b0, pred_taken} !== expv) begin n_err++; $display("FAIL alloc_hit_taken: got %0d want %0d", pred_taken, expv); end
    expv = sb.pop_front(); n_cmp++;
    if (pred_target !== expv) begin n_err++; $display("FAIL alloc_hit_target: got %h want %h", pred_target, expv); end
    tick();
    expv = sb.pop_front(); n_cmp++;
    if (pc !== expv) begin n_err++; $display("FAIL follow_pred_pc: got %h want %h", pc, expv); end
  endtask

  task automatic test_counter();
    sb.push_back(32'h1); sb.push_back(32'h8014);
    drive_ex(32'h8010, 1'b0, 32'h0, 1'b1, 32'h8100);
    exp_cnt++;
    expv = sb.pop_front(); n_cmp++;
    if ({31'b0, flush_seen} !== expv) begin n_err++; $display("FAIL nt1_flush: got %0d want %0d", flush_seen, expv); end
    expv = sb.pop_front(); n_cmp++;
    if (pc !== expv) begin n_err++; $display("FAIL nt1_pc: got %h want %h", pc, expv); end
    redirect(32'h8010);
    sb.push_back(32'h0); sb.push_back(32'h8100);
    expv = sb.pop_front(); n_cmp++;
    if ({31'b0, pred_taken} !== expv) begin n_err++; $display("FAIL wnt_taken: got %0d want %0d", pred_taken, expv); end
    expv = sb.pop_front(); n_cmp++;
    if (pred_target !== expv) begin n_err++; $display("FAIL wnt_target: got %h want %h", pred_target, expv); end
    sb.push_back(32'h0); sb.push_back(32'h8014);
    drive_ex(32'h8010, 1'b0, 32'h0, 1'b0, 32'h0);
    expv = sb.pop_front(); n_cmp++;
    if ({31'b0, flush_seen} !== expv) begin n_err++; $display("FAIL nt2_flush: got %0d want %0d", flush_seen, expv); end
    expv = sb.pop_front(); n_cmp++;
    if (pc !== expv) begin n_err++; $display("FAIL nt2_pc: got %h want %h", pc, expv); end
    drive_ex(32'h8010, 1'b0, 32'h0, 1'b0, 32'h0);
    redirect(32'h8010);
    sb.push_back(32'h0);
    expv = sb.pop_front(); n_cmp++;
    if ({31'b0, pred_taken} !== expv) begin n_err++; $display("FAIL ctr_floor: got %0d want %0d", pred_taken, expv); end
    drive_ex(32'h8010, 1'b1, 32'h8100, 1'b0, 32'h0);
    exp_cnt++;
    redirect(32'h8010);
    sb.push_back(32'h0);
    expv = sb.pop_front(); n_cmp++;
    if ({31'b0, pred_taken} !== expv) begin n_err++; $display("FAIL ctr_up_wnt: got %0d want %0d", pred_taken, expv); end
    drive_ex(32'h8010, 1'b1, 32'h8100, 1'b0, 32'h0);
    exp_cnt++;
    redirect(32'h8010);
    sb.push_back(32'h1);
    expv = sb.pop_front(); n_cmp++;
    if ({31'b0, pred_taken} !== expv) begin n_err++; $display("FAIL ctr_up_wt: got %0d want %0d", pred_taken, expv); end
    sb.push_back(32'h0); sb.push_back(32'h1);
    drive_ex(32'h8010, 1'b1, 32'h8100, 1'b1, 32'h8100);
    expv = sb.pop_front(); n_cmp++;
    if ({31'b0, flush_seen} !== expv) begin n_err++; $display("FAIL correct_pred_flush: got %0d want %0d", flush_seen, expv); end
    drive_ex(32'h8010, 1'b1, 32'h8100, 1'b1, 32'h8104);
    exp_cnt++;
    expv = sb.pop_front(); n_cmp++;
    if ({31'b0, flush_seen} !== expv) begin n_err++; $display("FAIL wrong_target_flush: got %0d want %0d", flush_seen, expv); end
    drive_ex(32'h8010, 1'b0, 32'h0, 1'b1, 32'h8100);
    exp_cnt++;
    redirect(32'h8010);
    sb.push_back(32'h1); sb.push_back(32'(exp_cnt));
    expv = sb.pop_front(); n_cmp++;
    if ({31'b0, pred_taken} !== expv) begin n_err++; $display("FAIL ctr_ceiling: got %0d want %0d", pred_taken, expv); end
    expv = sb.pop_front(); n_cmp++;
    if (mispred_count !== expv) begin n_err++; $display("FAIL counter_count: got %0d want %0d", mispred_count, expv); end
  endtask

  task automatic test_alias();
    sb.push_back(32'h1); sb.push_back(32'h8500);
    drive_ex(32'h8050, 1'b1, 32'h8500, 1'b0, 32'h0);
    exp_cnt++;
    expv = sb.pop_front(); n_cmp++;
    if ({31'b0, flush_seen} !== expv) begin n_err++; $display("FAIL alias_flush: got %0d want %0d", flush_seen, expv); end
    expv = sb.pop_front(); n_cmp++;
    if (pc !== expv) begin n_err++; $display("FAIL alias_pc: got %h want %h", pc, expv); end
    redirect(32'h8010);
    sb.push_back(32'h0); sb.push_back(32'h0);
    expv = sb.pop_front(); n_cmp++;
    if ({31'b0, pred_taken} !== expv) begin n_err++; $display("FAIL alias_old_taken: got %0d want %0d", pred_taken, expv); end
    expv = sb.pop_front(); n_cmp++;
    if (pred_target !== expv) begin n_err++; $display("FAIL alias_old_target: got %h want %h", pred_target, expv); end
    redirect(32'h8050);
    sb.push_back(32'h1); sb.push_back(32'h8500);
    expv = sb.pop_front(); n_cmp++;
    if ({31'b0, pred_taken} !== expv) begin n_err++; $display("FAIL alias_new_taken: got %0d want %0d", pred_taken, expv); end
    expv = sb.pop_front(); n_cmp++;
    if (pred_target !== expv) begin n_err++; $display("FAIL alias_new_target: got %h want %h", pred_target, expv); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(32'h8050);
      tick();
      expv = sb.pop_front(); n_cmp++;
      if (pc !== expv) begin n_err++; $display("FAIL stall_hold%0d: got %h want %h", i, pc, expv); end
    end
    sb.push_back(32'h1); sb.push_back(32'h9000); sb.push_back(32'h9000);
    drive_ex(32'h8080, 1'b1, 32'h9000, 1'b0, 32'h0);
    exp_cnt++;
    expv = sb.pop_front(); n_cmp++;
    if ({31'b0, flush_seen} !== expv) begin n_err++; $display("FAIL stall_mp_flush: got %0d want %0d", flush_seen, expv); end
    expv = sb.pop_front(); n_cmp++;
    if (pc !== expv) begin n_err++; $display("FAIL stall_mp_pc: got %h want %h", pc, expv); end
    tick();
    expv = sb.pop_front(); n_cmp++;
    if (pc !== expv) begin n_err++; $display("FAIL stall_after_pc: got %h want %h", pc, expv); end
    stall = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    redirect(32'hFFFF_FFF0);
    sb.push_back(32'h0);
    expv = sb.pop_front(); n_cmp++;
    if ({31'b0, pred_taken} !== expv) begin n_err++; $display("FAIL wrap_pred: got %0d want %0d", pred_taken, expv); end
    e = 32'hFFFF_FFF0;
    for (int i = 1; i <= 4; i++) begin
      e = e + 32'd4;
      sb.push_back(e);
      tick();
      expv = sb.pop_front(); n_cmp++;
      if (pc !== expv) begin n_err++; $display("FAIL wrap_pc%0d: got %h want %h", i, pc, expv); end
    end
  endtask

  task automatic test_jalr();
    sb.push_back(32'h1); sb.push_back(32'h8200);
    drive_ex(32'h8020, 1'b1, 32'h8203, 1'b0, 32'h0);
    exp_cnt++;
    expv = sb.pop_front(); n_cmp++;
    if ({31'b0, flush_seen} !== expv) begin n_err++; $display("FAIL jalr_flush: got %0d want %0d", flush_seen, expv); end
    expv = sb.pop_front(); n_cmp++;
    if (pc !== expv) begin n_err++; $display("FAIL jalr_pc: got %h want %h", pc, expv); end
    redirect(32'h8020);
    sb.push_back(32'h1); sb.push_back(32'h8200); sb.push_back(32'h8200); sb.push_back(32'(exp_cnt));
    expv = sb.pop_front(); n_cmp++;
    if ({31'b0, pred_taken} !== expv) begin n_err++; $display("FAIL jalr_pred_taken: got %0d want %0d", pred_taken, expv); end
    expv = sb.pop_front(); n_cmp++;
    if (pred_target !== expv) begin n_err++; $display("FAIL jalr_pred_target: got %h want %h", pred_target, expv); end
    tick();
    expv = sb.pop_front(); n_cmp++;
    if (pc !== expv) begin n_err++; $display("FAIL jalr_follow_pc: got %h want %h", pc, expv); end
    expv = sb.pop_front(); n_cmp++;
    if (mispred_count !== expv) begin n_err++; $display("FAIL jalr_count: got %0d want %0d", mispred_count, expv); end
  endtask

  task automatic test_reset_mid();
    ex_valid = 1'b1; ex_is_ctrl = 1'b1; ex_pc = 32'h8300; ex_taken = 1'b1;
    ex_target = 32'h9400; ex_pred_taken = 1'b0; ex_pred_target = '0;
    #2 rst = 1'b1;
    #1;
    $display("reset asserted mid-cycle during redirect, pc=%h", pc);
    sb.push_back(32'h8000); sb.push_back(32'h0); sb.push_back(32'h8000);
    expv = sb.pop_front(); n_cmp++;
    if (pc !== expv) begin n_err++; $display("FAIL midrst_pc: got %h want %h", pc, expv); end
    expv = sb.pop_front(); n_cmp++;
    if (mispred_count !== expv) begin n_err++; $display("FAIL midrst_count: got %0d want %0d", mispred_count, expv); end
    tick();
    expv = sb.pop_front(); n_cmp++;
    if (pc !== expv) begin n_err++; $display("FAIL midrst_hold_pc: got %h want %h", pc, expv); end
    clear_ex();
    rst = 1'b0;
    exp_cnt = 0;
    redirect(32'h8020);
    sb.push_back(32'h0); sb.push_back(32'(exp_cnt));
    expv = sb.pop_front(); n_cmp++;
    if ({31'b0, pred_taken} !== expv) begin n_err++; $display("FAIL midrst_miss: got %0d want %0d", pred_taken, expv); end
    expv = sb.pop_front(); n_cmp++;
    if (mispred_count !== expv) begin n_err++; $display("FAIL midrst_recount: got %0d want %0d", mispred_count, expv); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_cnt = 0;
    flush_seen = 1'b0;
    rst = 1'b1;
    stall = 1'b0;
    clear_ex();
    test_reset();
    test_alloc();
    test_counter();
    test_alias();
    test_stall();
    test_wrap();
    test_jalr();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
